// File: rtl/huffman_decoder.sv
// huffman_decoder: captures a six-symbol Huffman code table and decodes a
// serial bitstream into symbol indices 1..6.
// Latency: one registered cycle from the final code bit to sym_valid.
// Backpressure: none. A bit is consumed in each DECODE cycle with bit_valid=1.
//
// Ports:
//   clk, reset         rising-edge clock; asynchronous active-high reset
//   code_valid         one-cycle pulse that captures HC1..HC6 / M1..M6
//   HC1..HC6, M1..M6   code (LSB first on the wire) and contiguous-ones mask
//   bit_valid, bit_in  serial code bit and its qualifier
//   tbl_ready/tbl_err  table loaded and well-formed / malformed (level)
//   sym_valid/sym_out  one-cycle pulse with the decoded symbol index
//   dec_err            one-cycle pulse: CODE_W bits collected with no match
// Optional macro HUFF_DEC_CNT_EN adds DCNT1..DCNT6, one saturating 8-bit
// counter per decoded symbol. The counters clear on reset and on code_valid.
module huffman_decoder #(
  parameter int CODE_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              code_valid,
  input  logic [CODE_W-1:0] HC1,
  input  logic [CODE_W-1:0] HC2,
  input  logic [CODE_W-1:0] HC3,
  input  logic [CODE_W-1:0] HC4,
  input  logic [CODE_W-1:0] HC5,
  input  logic [CODE_W-1:0] HC6,
  input  logic [CODE_W-1:0] M1,
  input  logic [CODE_W-1:0] M2,
  input  logic [CODE_W-1:0] M3,
  input  logic [CODE_W-1:0] M4,
  input  logic [CODE_W-1:0] M5,
  input  logic [CODE_W-1:0] M6,
  input  logic              bit_valid,
  input  logic              bit_in,
  output logic              tbl_ready,
  output logic              tbl_err,
  output logic              sym_valid,
  output logic [2:0]        sym_out,
  output logic              dec_err
`ifdef HUFF_DEC_CNT_EN
  ,
  output logic [7:0]        DCNT1,
  output logic [7:0]        DCNT2,
  output logic [7:0]        DCNT3,
  output logic [7:0]        DCNT4,
  output logic [7:0]        DCNT5,
  output logic [7:0]        DCNT6
`endif
);

  localparam int LW = $clog2(CODE_W + 1);

  typedef enum logic [1:0] {NO_TABLE, DECODE, BAD_TABLE} state_t;

  state_t            r_state;
  logic [CODE_W-1:0] r_hc   [6];
  logic [CODE_W-1:0] r_m    [6];
  logic [LW-1:0]     r_lenk [6];
  logic [CODE_W-1:0] r_acc;
  logic [LW-1:0]     r_len;

  logic [CODE_W-1:0] w_hc_in [6];
  logic [CODE_W-1:0] w_m_in  [6];
  logic [CODE_W-1:0] w_acc_nxt;
  logic [LW-1:0]     w_len_nxt;
  logic              w_len_full;
  logic [5:0]        w_match;
  logic              w_hit;
  logic [2:0]        w_sym;
  logic              w_bad_tbl;
  logic              w_consume;

  assign w_hc_in[0] = HC1;
  assign w_hc_in[1] = HC2;
  assign w_hc_in[2] = HC3;
  assign w_hc_in[3] = HC4;
  assign w_hc_in[4] = HC5;
  assign w_hc_in[5] = HC6;
  assign w_m_in[0]  = M1;
  assign w_m_in[1]  = M2;
  assign w_m_in[2]  = M3;
  assign w_m_in[3]  = M4;
  assign w_m_in[4]  = M5;
  assign w_m_in[5]  = M6;

  function automatic logic [LW-1:0] popcount(input logic [CODE_W-1:0] m);
    logic [LW-1:0] c;
    c = '0;
    for (int i = 0; i < CODE_W; i++) c = c + LW'(m[i]);
    return c;
  endfunction

  // A well-formed mask is 2^n-1: adding one clears every set bit.
  function automatic logic malformed(input logic [CODE_W-1:0] m);
    logic [CODE_W-1:0] m_p1;
    m_p1 = m + 1'b1;
    return (m != '0) && ((m & m_p1) != '0);
  endfunction

  always_comb begin
    w_bad_tbl = 1'b1;
    for (int k = 0; k < 6; k++)
      if (w_m_in[k] != '0) w_bad_tbl = 1'b0;
    for (int k = 0; k < 6; k++)
      if (malformed(w_m_in[k])) w_bad_tbl = 1'b1;
  end

  // The accumulator is zero above r_len, so OR-ing inserts the new bit.
  assign w_acc_nxt  = r_acc | ({{(CODE_W-1){1'b0}}, bit_in} << r_len);
  assign w_len_nxt  = r_len + 1'b1;
  assign w_len_full = (w_len_nxt == LW'(CODE_W));
  // A load in the same cycle drops the bit.
  assign w_consume  = (r_state == DECODE) && bit_valid && !code_valid;

  // The stored mask is contiguous, so masked equality checks exactly lenk bits.
  always_comb begin
    for (int k = 0; k < 6; k++)
      w_match[k] = (r_lenk[k] != '0) && (r_lenk[k] == w_len_nxt) &&
                   ((w_acc_nxt & r_m[k]) == (r_hc[k] & r_m[k]));
  end

  // Scan from the highest index down so the lowest matching index wins.
  always_comb begin
    w_hit = 1'b0;
    w_sym = 3'd0;
    for (int k = 5; k >= 0; k--) begin
      if (w_match[k]) begin
        w_hit = 1'b1;
        w_sym = 3'(k + 1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= NO_TABLE;
      r_acc     <= '0;
      r_len     <= '0;
      tbl_ready <= 1'b0;
      tbl_err   <= 1'b0;
      sym_valid <= 1'b0;
      sym_out   <= 3'd0;
      dec_err   <= 1'b0;
      for (int k = 0; k < 6; k++) begin
        r_hc[k]   <= '0;
        r_m[k]    <= '0;
        r_lenk[k] <= '0;
      end
    end else begin
      sym_valid <= 1'b0;
      dec_err   <= 1'b0;
      if (code_valid) begin
        for (int k = 0; k < 6; k++) begin
          r_hc[k]   <= w_hc_in[k];
          r_m[k]    <= w_m_in[k];
          r_lenk[k] <= popcount(w_m_in[k]);
        end
        r_acc     <= '0;
        r_len     <= '0;
        tbl_ready <= !w_bad_tbl;
        tbl_err   <= w_bad_tbl;
        r_state   <= w_bad_tbl ? BAD_TABLE : DECODE;
      end else if (w_consume) begin
        if (w_hit) begin
          sym_valid <= 1'b1;
          sym_out   <= w_sym;
          r_acc     <= '0;
          r_len     <= '0;
        end else if (w_len_full) begin
          dec_err <= 1'b1;
          r_acc   <= '0;
          r_len   <= '0;
        end else begin
          r_acc <= w_acc_nxt;
          r_len <= w_len_nxt;
        end
      end
    end
  end

`ifdef HUFF_DEC_CNT_EN
  logic [7:0] r_cnt [6];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 6; k++) r_cnt[k] <= 8'd0;
    end else if (code_valid) begin
      for (int k = 0; k < 6; k++) r_cnt[k] <= 8'd0;
    end else if (w_consume && w_hit) begin
      for (int k = 0; k < 6; k++)
        if (w_sym == 3'(k + 1) && r_cnt[k] != 8'hFF) r_cnt[k] <= r_cnt[k] + 8'd1;
    end
  end

  assign DCNT1 = r_cnt[0];
  assign DCNT2 = r_cnt[1];
  assign DCNT3 = r_cnt[2];
  assign DCNT4 = r_cnt[3];
  assign DCNT5 = r_cnt[4];
  assign DCNT6 = r_cnt[5];
`endif

endmodule

// File: tb/tb_huffman_decoder.sv
// Directed bench for huffman_decoder. Each vector is one clock cycle. Its
// expectations describe the registered outputs after the edge that samples it.
module tb_huffman_decoder;

  logic       clk;
  logic       reset;
  logic       code_valid;
  logic [7:0] hc [6];
  logic [7:0] m  [6];
  logic       bit_valid;
  logic       bit_in;
  logic       tbl_ready;
  logic       tbl_err;
  logic       sym_valid;
  logic [2:0] sym_out;
  logic       dec_err;
`ifdef HUFF_DEC_CNT_EN
  logic [7:0] dcnt [6];
`endif

  int checks   = 0;
  int failures = 0;

  huffman_decoder #(.CODE_W(8)) dut (
    .clk(clk), .reset(reset), .code_valid(code_valid),
    .HC1(hc[0]), .HC2(hc[1]), .HC3(hc[2]), .HC4(hc[3]), .HC5(hc[4]), .HC6(hc[5]),
    .M1(m[0]), .M2(m[1]), .M3(m[2]), .M4(m[3]), .M5(m[4]), .M6(m[5]),
    .bit_valid(bit_valid), .bit_in(bit_in),
    .tbl_ready(tbl_ready), .tbl_err(tbl_err),
    .sym_valid(sym_valid), .sym_out(sym_out), .dec_err(dec_err)
`ifdef HUFF_DEC_CNT_EN
    ,
    .DCNT1(dcnt[0]), .DCNT2(dcnt[1]), .DCNT3(dcnt[2]),
    .DCNT4(dcnt[3]), .DCNT5(dcnt[4]), .DCNT6(dcnt[5])
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // tsel: 0 no load, 1 good table, 2 good table with M6 unused,
  //       3 M3=05 (malformed), 4 all masks zero (malformed)
  typedef struct {
    int tsel;
    bit bv;
    bit bi;
    bit sv;
    int sym;
    bit de;
    bit rdy;
    bit err;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int t, input bit bv, input bit bi, input bit sv,
                     input int sym, input bit de, input bit rdy, input bit err);
    vq.push_back('{t, bv, bi, sv, sym, de, rdy, err});
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_table(input int t);
    hc[0] = 8'h00; hc[1] = 8'h01; hc[2] = 8'h03;
    hc[3] = 8'h07; hc[4] = 8'h0F; hc[5] = 8'h1F;
    m[0]  = 8'h01; m[1]  = 8'h03; m[2]  = 8'h07;
    m[3]  = 8'h0F; m[4]  = 8'h1F; m[5]  = 8'h1F;
    if (t == 2) m[5] = 8'h00;
    if (t == 3) m[2] = 8'h05;
    if (t == 4) for (int k = 0; k < 6; k++) m[k] = 8'h00;
  endtask

  // Drive on the falling edge, then settle just after the rising edge.
  task automatic cyc(input int t, input bit bv, input bit bi);
    @(negedge clk);
    code_valid = (t != 0);
    if (t != 0) set_table(t);
    bit_valid = bv;
    bit_in    = bi;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input bit sv, input int sym,
                          input bit de, input bit rdy, input bit err);
    chk({tag, "_sym_valid"}, sym_valid, sv);
    chk({tag, "_dec_err"}, dec_err, de);
    chk({tag, "_tbl_ready"}, tbl_ready, rdy);
    chk({tag, "_tbl_err"}, tbl_err, err);
    if (sv) chk({tag, "_sym_out"}, sym_out, sym);
  endtask

  initial begin
    reset = 1'b1;
    code_valid = 1'b0;
    bit_valid = 1'b0;
    bit_in = 1'b0;
    set_table(1);

    // Expected-value table
    // Stream 0 | 1,0 | 1,1,1,1,1 gives symbols 1, 2 and 6.
    add(1, 0, 0, 0, 0, 0, 1, 0);
    add(0, 1, 0, 1, 1, 0, 1, 0);
    add(0, 1, 1, 0, 0, 0, 1, 0);
    add(0, 1, 0, 1, 2, 0, 1, 0);
    for (int i = 0; i < 4; i++) add(0, 1, 1, 0, 0, 0, 1, 0);
    add(0, 1, 1, 1, 6, 0, 1, 0);
    // A length-1 code back to back.
    for (int i = 0; i < 4; i++) add(0, 1, 0, 1, 1, 0, 1, 0);
    // Partial codeword held across a gap.
    add(0, 1, 1, 0, 0, 0, 1, 0);
    add(0, 1, 1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 1, 0, 1, 3, 0, 1, 0);
    // M6 unused: eight 1s give dec_err, then a cleared accumulator decodes 0 as symbol 1.
    add(2, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 7; i++) add(0, 1, 1, 0, 0, 0, 1, 0);
    add(0, 1, 1, 0, 0, 1, 1, 0);
    add(0, 1, 0, 1, 1, 0, 1, 0);
    // Malformed tables block decoding. Reloading the good table restores it.
    add(3, 0, 0, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 1);
    add(0, 1, 1, 0, 0, 0, 0, 1);
    add(4, 0, 0, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 1, 0);
    add(0, 1, 0, 1, 1, 0, 1, 0);
    // A load that coincides with a bit discards the partial codeword 1,1 and the bit.
    add(0, 1, 1, 0, 0, 0, 1, 0);
    add(0, 1, 1, 0, 0, 0, 1, 0);
    add(1, 1, 1, 0, 0, 0, 1, 0);
    add(0, 1, 0, 1, 1, 0, 1, 0);

    // Reset state
    #1;
    chk("rst_tbl_ready", tbl_ready, 0);
    chk("rst_tbl_err", tbl_err, 0);
    chk("rst_sym_valid", sym_valid, 0);
    chk("rst_sym_out", sym_out, 0);
    chk("rst_dec_err", dec_err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    // Bits are ignored before any table has been loaded.
    cyc(0, 1, 0);
    chk_outs("notbl", 0, 0, 0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      cyc(vq[i].tsel, vq[i].bv, vq[i].bi);
      chk_outs($sformatf("v%0d", i), vq[i].sv, vq[i].sym, vq[i].de,
               vq[i].rdy, vq[i].err);
    end

`ifdef HUFF_DEC_CNT_EN
    chk("dcnt1", dcnt[0], 1);
    for (int k = 1; k < 6; k++) chk($sformatf("dcnt%0d", k + 1), dcnt[k], 0);
`endif

    // Reset mid-codeword: the partial codeword 1,1 must not survive.
    cyc(0, 1, 1);
    cyc(0, 1, 1);
    @(negedge clk);
    bit_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk_outs("midrst", 0, 0, 0, 0, 0);
    chk("midrst_sym_out", sym_out, 0);
    @(negedge clk);
    reset = 1'b0;
    cyc(0, 1, 0);
    chk_outs("postrst_ignored", 0, 0, 0, 0, 0);
    cyc(1, 0, 0);
    chk_outs("postrst_load", 0, 0, 0, 1, 0);
    cyc(0, 1, 0);
    chk_outs("postrst_sym", 1, 1, 0, 1, 0);
    cyc(0, 0, 0);
    chk_outs("idle", 0, 0, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
